uart_packet_decoder: RTL and testbench

Byte-stream command parser between the UART receiver and the on-chip data memories. It frames received bytes into packets (opcode, address, optional header checksum, payload), assembles payload bytes into memory words and issues write or read-burst requests. It replaces the fixed 3-byte-header / fixed-length handling in the comms top level with header length, word width and burst length set by parameters. It adds inter-byte timeout recovery and error reporting.

---
 rtl/uart_packet_decoder_if.sv | 43 ++++
 rtl/uart_packet_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_uart_packet_decoder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_packet_decoder_if.sv
// Bus bundle between the UART packet decoder and its byte source and memory ports.
// Latency: none, this is a plain signal bundle.
// Backpressure: the write and read request channels use valid/ready. The byte strobe has no backpressure.
// Ports: rx_* carries the received byte stream, wr_* is the word write request and rd_* is the read-burst request.
// busy_out and err_* report parser status.
// master = decoder side, slave = environment (UART receiver, memory, readback engine).
interface uart_packet_decoder_if #(
    parameter int ADDR_BYTES = 2,
    parameter int WORD_BYTES = 8,
    parameter int BURST_LEN  = 32
);
    localparam int ADDR_W = 8 * ADDR_BYTES;
    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int LEN_W  = $clog2(BURST_LEN + 1);

    logic              rx_valid_in;
    logic [7:0]        rx_byte_in;
    logic              wr_valid_out;
    logic              wr_ready_in;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [DATA_W-1:0] wr_data_out;
    logic              rd_valid_out;
    logic              rd_ready_in;
    logic [ADDR_W-1:0] rd_addr_out;
    logic [LEN_W-1:0]  rd_len_out;
    logic              busy_out;
    logic              err_out;
    logic [1:0]        err_code_out;

    modport master (
        input  rx_valid_in, rx_byte_in, wr_ready_in, rd_ready_in,
        output wr_valid_out, wr_addr_out, wr_data_out,
        output rd_valid_out, rd_addr_out, rd_len_out,
        output busy_out, err_out, err_code_out
    );

    modport slave (
        output rx_valid_in, rx_byte_in, wr_ready_in, rd_ready_in,
        input  wr_valid_out, wr_addr_out, wr_data_out,
        input  rd_valid_out, rd_addr_out, rd_len_out,
        input  busy_out, err_out, err_code_out
    );
endinterface

// File: rtl/uart_packet_decoder.sv
// Frames UART bytes into opcode/address/[checksum]/payload packets and issues word writes or read-burst requests.
// Latency: a write word or read request is presented 1 cycle after the strobe of its completing byte.
// Backpressure: there is a one-entry write holding register. A word that completes while it is full and not
// being accepted is dropped with err code 2. A read request holds until it is accepted.
// Ports: clk_in/rst_in (async, active-high) plus bus (uart_packet_decoder_if.master).
// Optional UART_PKT_CHECKSUM_EN adds a header XOR checksum byte, CHK and DISCARD states and err code 3.
module uart_packet_decoder #(
    parameter int ADDR_BYTES     = 2,
    parameter int WORD_BYTES     = 8,
    parameter int BURST_LEN      = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    uart_packet_decoder_if.master  bus
);
    localparam int ADDR_W = 8 * ADDR_BYTES;
    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int LEN_W  = $clog2(BURST_LEN + 1);
    localparam int AC_W   = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam int WB_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int BL_W   = (BURST_LEN  > 1) ? $clog2(BURST_LEN)  : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ADDR    = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd3;
    localparam logic [2:0] RD_REQ  = 3'd4;
`ifdef UART_PKT_CHECKSUM_EN
    localparam logic [2:0] CHK     = 3'd2;
    localparam logic [2:0] DISCARD = 3'd5;
`endif

    logic [2:0]        state;
    logic [AC_W-1:0]   addr_cnt;
    logic [WB_W-1:0]   byte_cnt;
    logic [BL_W-1:0]   word_idx;
    logic [ADDR_W-1:0] base_addr;
    logic [DATA_W-1:0] word_buf;
    logic              is_read;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              err;
    logic [1:0]        err_code;
    logic [TO_W-1:0]   tmo_cnt;
`ifdef UART_PKT_CHECKSUM_EN
    logic [7:0]        chk_acc;
`endif

    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] word_next;
    logic              addr_last;
    logic              word_done;
    logic              burst_done;
    logic              tmo_active;
    logic              tmo_expire;

    // The incoming byte merged into the partially assembled address or word.
    always_comb begin
        addr_next = base_addr;
        addr_next[8*addr_cnt +: 8] = bus.rx_byte_in;
        word_next = word_buf;
        word_next[8*byte_cnt +: 8] = bus.rx_byte_in;
    end

    assign addr_last  = (addr_cnt == AC_W'(ADDR_BYTES - 1));
    assign word_done  = (byte_cnt == WB_W'(WORD_BYTES - 1));
    assign burst_done = (word_idx == BL_W'(BURST_LEN - 1));
`ifdef UART_PKT_CHECKSUM_EN
    assign tmo_active = (state == ADDR) || (state == CHK) || (state == PAYLOAD) || (state == DISCARD);
`else
    assign tmo_active = (state == ADDR) || (state == PAYLOAD);
`endif
    // The expiry fires on the TIMEOUT_CYCLES-th idle edge after the last byte. A byte arriving on that edge wins.
    assign tmo_expire = tmo_active && !bus.rx_valid_in && (tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            byte_cnt  <= '0;
            word_idx  <= '0;
            base_addr <= '0;
            word_buf  <= '0;
            is_read   <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            tmo_cnt   <= '0;
`ifdef UART_PKT_CHECKSUM_EN
            chk_acc   <= '0;
`endif
        end else begin
            err <= 1'b0;
            // A word load later in this block overrides this clear, which gives accept-plus-reload in one cycle.
            if (wr_valid && bus.wr_ready_in)
                wr_valid <= 1'b0;

            if (bus.rx_valid_in || !tmo_active)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;

            case (state)
                IDLE: begin
                    addr_cnt <= '0;
                    byte_cnt <= '0;
                    word_idx <= '0;
                    if (bus.rx_valid_in) begin
                        if (bus.rx_byte_in[7:1] == 7'd0) begin
                            is_read <= bus.rx_byte_in[0];
                            state   <= ADDR;
`ifdef UART_PKT_CHECKSUM_EN
                            chk_acc <= bus.rx_byte_in;
`endif
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'd0;
                        end
                    end
                end
                ADDR: if (bus.rx_valid_in) begin
                    base_addr <= addr_next;
`ifdef UART_PKT_CHECKSUM_EN
                    chk_acc   <= chk_acc ^ bus.rx_byte_in;
`endif
                    if (addr_last) begin
`ifdef UART_PKT_CHECKSUM_EN
                        state <= CHK;
`else
                        state <= is_read ? RD_REQ : PAYLOAD;
`endif
                    end else begin
                        addr_cnt <= addr_cnt + 1'b1;
                    end
                end
`ifdef UART_PKT_CHECKSUM_EN
                CHK: if (bus.rx_valid_in) begin
                    if (bus.rx_byte_in == chk_acc) begin
                        state <= is_read ? RD_REQ : PAYLOAD;
                    end else begin
                        err      <= 1'b1;
                        err_code <= 2'd3;
                        state    <= is_read ? IDLE : DISCARD;
                    end
                end
                // The same byte/word counting as PAYLOAD is used, but nothing is written.
                DISCARD: if (bus.rx_valid_in) begin
                    if (word_done) begin
                        byte_cnt <= '0;
                        if (burst_done)
                            state <= IDLE;
                        else
                            word_idx <= word_idx + 1'b1;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
`endif
                PAYLOAD: if (bus.rx_valid_in) begin
                    word_buf <= word_next;
                    if (word_done) begin
                        byte_cnt <= '0;
                        if (!wr_valid || bus.wr_ready_in) begin
                            wr_valid <= 1'b1;
                            wr_data  <= word_next;
                            wr_addr  <= base_addr + ADDR_W'(word_idx);
                        end else begin
                            // The holding register is still occupied, so this word is lost.
                            // The index still advances so later words keep their addresses.
                            err      <= 1'b1;
                            err_code <= 2'd2;
                        end
                        if (burst_done)
                            state <= IDLE;
                        else
                            word_idx <= word_idx + 1'b1;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                RD_REQ: if (bus.rd_ready_in) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (tmo_expire) begin
                state    <= IDLE;
                err      <= 1'b1;
                err_code <= 2'd1;
            end
        end
    end

    assign bus.wr_valid_out = wr_valid;
    assign bus.wr_addr_out  = wr_addr;
    assign bus.wr_data_out  = wr_data;
    assign bus.rd_valid_out = (state == RD_REQ);
    assign bus.rd_addr_out  = base_addr;
    assign bus.rd_len_out   = LEN_W'(BURST_LEN);
    assign bus.busy_out     = (state != IDLE) || wr_valid;
    assign bus.err_out      = err;
    assign bus.err_code_out = err_code;
endmodule

// File: tb/tb_uart_packet_decoder.sv
module tb_uart_packet_decoder;
    localparam int AB = 2;
    localparam int WB = 8;
    localparam int BL = 32;
    localparam int TO = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_packet_decoder_if #(.ADDR_BYTES(AB), .WORD_BYTES(WB), .BURST_LEN(BL)) bus ();

    uart_packet_decoder #(
        .ADDR_BYTES(AB), .WORD_BYTES(WB), .BURST_LEN(BL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] wq_addr[$];
    logic [63:0] wq_data[$];
    int          err_cnt;
    int          rd_cnt;
    logic [1:0]  last_code;

    // Records accepted requests and error pulses. It samples on the falling edge, between input changes.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_valid_out && bus.wr_ready_in) begin
                wq_addr.push_back(bus.wr_addr_out);
                wq_data.push_back(bus.wr_data_out);
            end
            if (bus.rd_valid_out && bus.rd_ready_in) rd_cnt = rd_cnt + 1;
            if (bus.err_out) begin
                err_cnt   = err_cnt + 1;
                last_code = bus.err_code_out;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        err_cnt   = 0;
        rd_cnt    = 0;
        last_code = 2'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_valid_in = 1'b1;
        bus.rx_byte_in  = b;
        @(posedge clk); #1;
        bus.rx_valid_in = 1'b0;
    endtask

    task automatic send_header(input logic [7:0] op, input logic [15:0] addr);
        send_byte(op);
        send_byte(addr[7:0]);
        send_byte(addr[15:8]);
`ifdef UART_PKT_CHECKSUM_EN
        send_byte(op ^ addr[7:0] ^ addr[15:8]);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int n_edges;
    bit found;
    int bad;

    initial begin
        rst = 1'b1;
        bus.rx_valid_in = 1'b0;
        bus.rx_byte_in  = 8'h00;
        bus.wr_ready_in = 1'b1;
        bus.rd_ready_in = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_wr_valid", bus.wr_valid_out, 0);
        check("rst_rd_valid", bus.rd_valid_out, 0);
        check("rst_busy", bus.busy_out, 0);
        check("rst_err", bus.err_out, 0);
        check("rst_err_code", bus.err_code_out, 0);
        check("rd_len", bus.rd_len_out, 32);

        // Full write burst with ready tied high.
        clear_mon();
        send_header(8'h00, 16'h0010);
        for (int n = 0; n < 256; n++) begin
            send_byte(8'(8'h36 + n));
            if (n == 6) check("wr_valid_before_word", bus.wr_valid_out, 0);
            if (n == 7) begin
                check("wr_valid_after_word", bus.wr_valid_out, 1);
                check("wr_addr_word0", bus.wr_addr_out, 16'h0010);
                check("wr_data_word0", bus.wr_data_out, 64'h3D3C3B3A39383736);
            end
        end
        idle(4);
        check("wr_count", wq_addr.size(), 32);
        check("wr_first_addr", wq_addr[0], 16'h0010);
        check("wr_first_data", wq_data[0], 64'h3D3C3B3A39383736);
        check("wr_last_addr", wq_addr[31], 16'h002F);
        check("wr_last_data", wq_data[31], 64'h35343332_31302F2E);
        bad = 0;
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] !== 16'(16'h0010 + i)) bad++;
        check("wr_addr_sequence_bad", bad, 0);
        check("wr_no_err", err_cnt, 0);
        check("wr_idle_busy", bus.busy_out, 0);

        // Read request held for 10 cycles of ready low. A stray byte meanwhile is ignored.
        clear_mon();
        send_byte(8'h01);
        send_byte(8'h04);
        check("rd_not_early", bus.rd_valid_out, 0);
        send_byte(8'h00);
`ifdef UART_PKT_CHECKSUM_EN
        send_byte(8'h05);
`endif
        check("rd_valid", bus.rd_valid_out, 1);
        check("rd_addr", bus.rd_addr_out, 16'h0004);
        check("rd_busy", bus.busy_out, 1);
        send_byte(8'hAA);
        idle(8);
        check("rd_held_valid", bus.rd_valid_out, 1);
        check("rd_held_addr", bus.rd_addr_out, 16'h0004);
        check("rd_len_held", bus.rd_len_out, 32);
        check("rd_stray_no_err", err_cnt, 0);
        bus.rd_ready_in = 1'b1;
        @(posedge clk); #1;
        bus.rd_ready_in = 1'b0;
        check("rd_dropped", bus.rd_valid_out, 0);
        check("rd_busy_after", bus.busy_out, 0);
        check("rd_accept_count", rd_cnt, 1);

        // A bad opcode is followed by a valid write packet.
        clear_mon();
        send_byte(8'h04);
        idle(2);
        check("badop_err_count", err_cnt, 1);
        check("badop_code", last_code, 0);
        check("badop_busy", bus.busy_out, 0);
        check("badop_no_write", wq_addr.size(), 0);
        check("badop_no_read", rd_cnt, 0);
        send_header(8'h00, 16'h0200);
        for (int n = 0; n < 256; n++) send_byte(8'(n));
        idle(4);
        check("badop_next_wr_count", wq_addr.size(), 32);
        check("badop_next_last_addr", wq_addr[31], 16'h021F);
        check("badop_next_no_new_err", err_cnt, 1);

        // Timeout after a partial word.
        clear_mon();
        send_header(8'h00, 16'h0010);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        n_edges = 0;
        found = 1'b0;
        for (int i = 0; i < TO + 10 && !found; i++) begin
            @(posedge clk);
            n_edges++;
            @(negedge clk);
            if (bus.err_out) found = 1'b1;
        end
        check("tmo_latency", n_edges, TO);
        check("tmo_code", bus.err_code_out, 1);
        check("tmo_busy", bus.busy_out, 0);
        idle(2);
        check("tmo_no_write", wq_addr.size(), 0);
        check("tmo_single_pulse", err_cnt, 1);

        // Write overrun: ready is low for two word times.
        clear_mon();
        bus.wr_ready_in = 1'b0;
        send_header(8'h00, 16'h0100);
        for (int n = 0; n < 256; n++) begin
            send_byte(8'(n));
            if (n == 14) begin
                check("ovr_word0_held", bus.wr_valid_out, 1);
                check("ovr_word0_data", bus.wr_data_out, 64'h0706050403020100);
            end
            if (n == 15) bus.wr_ready_in = 1'b1;
        end
        idle(4);
        check("ovr_err_count", err_cnt, 1);
        check("ovr_code", last_code, 2);
        check("ovr_code_held", bus.err_code_out, 2);
        check("ovr_wr_count", wq_addr.size(), 31);
        check("ovr_first_addr", wq_addr[0], 16'h0100);
        check("ovr_first_data", wq_data[0], 64'h0706050403020100);
        check("ovr_second_addr", wq_addr[1], 16'h0102);
        check("ovr_second_data", wq_data[1], 64'h1716151413121110);
        check("ovr_last_addr", wq_addr[30], 16'h011F);

        // Reset in the middle of a packet with a write pending.
        clear_mon();
        bus.wr_ready_in = 1'b0;
        send_header(8'h00, 16'h0300);
        for (int n = 0; n < 10; n++) send_byte(8'(n));
        check("mid_wr_pending", bus.wr_valid_out, 1);
        rst = 1'b1;
        #2;
        check("mid_rst_wr_valid", bus.wr_valid_out, 0);
        check("mid_rst_busy", bus.busy_out, 0);
        check("mid_rst_err_code", bus.err_code_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.wr_ready_in = 1'b1;
        idle(2);

`ifdef UART_PKT_CHECKSUM_EN
        // A bad checksum discards the burst. The next packet, with the correct checksum, writes every word.
        clear_mon();
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h11);
        idle(1);
        check("chk_err_count", err_cnt, 1);
        check("chk_code", last_code, 3);
        check("chk_discard_busy", bus.busy_out, 1);
        for (int n = 0; n < 256; n++) send_byte(8'(n));
        idle(2);
        check("chk_discard_done", bus.busy_out, 0);
        check("chk_no_write", wq_addr.size(), 0);
        send_header(8'h00, 16'h0010);
        for (int n = 0; n < 256; n++) send_byte(8'(n));
        idle(4);
        check("chk_good_wr_count", wq_addr.size(), 32);
        check("chk_good_first_addr", wq_addr[0], 16'h0010);
        check("chk_good_err_count", err_cnt, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
